// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the multicycle MIPS control FSM and the
// datapath it steers.
//   * Primary opcodes (IR[31:26]) recognised by the controller
//   * FSM state encodings, also exported on the debug State port
//   * Mux/operation codes for ALUOp, ALUIn2Sel and PCSrc
//   * ctrl_t: one bundle of every control output, built by the FSM
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // State encodings (4 bits, visible on the debug port)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // ALU operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  // ALU input 2 select
  localparam logic [1:0] ALU2_B    = 2'b00;
  localparam logic [1:0] ALU2_ONE  = 2'b01;
  localparam logic [1:0] ALU2_SIMM = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JTA    = 2'b10;

  // ALU input 1 select
  localparam logic ALU1_PC = 1'b0;
  localparam logic ALU1_A  = 1'b1;

  typedef struct packed {
    logic       pc_en;
    logic       iord_sel;
    logic       ir_we;
    logic       dm_we;
    logic       rf_we;
    logic       rfd_sel;
    logic       mtorf_sel;
    logic       alu_in1_sel;
    logic [1:0] alu_in2_sel;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                                      op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- control unit of a multicycle MIPS subset
// (lw, sw, R-type, addi, beq, j).
//
// Parameter
//   ILLEGAL_HALT  1: park in HALT on an undecodable opcode, 0: back to FETCH
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset, loads FETCH
//   Opcode     IR[31:26], held stable by the IR from DECODE to end of instr
//   Zero       ALU zero flag (qualifies PCEn in BRANCH)
//   PCEn, IorDSel, IRWE, DMWE, RFWE, RFDSel, MtoRFSel,
//   ALUIn1Sel, ALUIn2Sel, ALUOp, PCSrc   datapath controls
//   IllegalOp  one-cycle flag in DECODE for an unknown opcode
//   State      current state encoding (debug)
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorDSel,
  output logic       IRWE,
  output logic       DMWE,
  output logic       RFWE,
  output logic       RFDSel,
  output logic       MtoRFSel,
  output logic       ALUIn1Sel,
  output logic [1:0] ALUIn2Sel,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state, state_nxt;
  ctrl_t  ctrl;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic. Opcode is only consulted in DECODE and MEMADR, so
  // the IR is free to change in every other state.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      // Only lw/sw reach MEMADR; anything other than sw is treated as a load.
      S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  state_nxt = S_FETCH;
      S_EXEC_R: state_nxt = S_WB_R;
      S_WB_R:   state_nxt = S_FETCH;
      S_EXEC_I: state_nxt = S_WB_I;
      S_WB_I:   state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;   // unused encodings recover
    endcase
  end

  // Output decode. Moore from state, with two exceptions: PCEn in BRANCH
  // follows Zero, and IllegalOp in DECODE follows the opcode being decoded.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.iord_sel    = 1'b0;
        ctrl.ir_we       = 1'b1;
        ctrl.alu_in1_sel = ALU1_PC;
        ctrl.alu_in2_sel = ALU2_ONE;
        ctrl.alu_op      = ALUOP_ADD;
        ctrl.pc_src      = PCSRC_ALU;
        ctrl.pc_en       = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_in1_sel = ALU1_PC;
        ctrl.alu_in2_sel = ALU2_SIMM;
        ctrl.alu_op      = ALUOP_ADD;
        ctrl.illegal_op  = ~op_is_legal(Opcode);
      end
      S_MEMADR, S_EXEC_I: begin
        ctrl.alu_in1_sel = ALU1_A;
        ctrl.alu_in2_sel = ALU2_SIMM;
        ctrl.alu_op      = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord_sel = 1'b1;
      S_MEMWB: begin
        ctrl.rf_we     = 1'b1;
        ctrl.rfd_sel   = 1'b0;
        ctrl.mtorf_sel = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord_sel = 1'b1;
        ctrl.dm_we    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_in1_sel = ALU1_A;
        ctrl.alu_in2_sel = ALU2_B;
        ctrl.alu_op      = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl.rf_we     = 1'b1;
        ctrl.rfd_sel   = 1'b1;
        ctrl.mtorf_sel = 1'b0;
      end
      S_WB_I: begin
        ctrl.rf_we     = 1'b1;
        ctrl.rfd_sel   = 1'b0;
        ctrl.mtorf_sel = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_in1_sel = ALU1_A;
        ctrl.alu_in2_sel = ALU2_B;
        ctrl.alu_op      = ALUOP_SUB;
        ctrl.pc_src      = PCSRC_ALUOUT;
        ctrl.pc_en       = Zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JTA;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;               // HALT and unused encodings
    endcase

    // Reset blocks every architectural write and the illegal flag, even in
    // the cycle before the state register has returned to FETCH.
    if (RST) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ir_we      = 1'b0;
      ctrl.dm_we      = 1'b0;
      ctrl.rf_we      = 1'b0;
      ctrl.illegal_op = 1'b0;
    end
  end

  assign PCEn      = ctrl.pc_en;
  assign IorDSel   = ctrl.iord_sel;
  assign IRWE      = ctrl.ir_we;
  assign DMWE      = ctrl.dm_we;
  assign RFWE      = ctrl.rf_we;
  assign RFDSel    = ctrl.rfd_sel;
  assign MtoRFSel  = ctrl.mtorf_sel;
  assign ALUIn1Sel = ctrl.alu_in1_sel;
  assign ALUIn2Sel = ctrl.alu_in2_sel;
  assign ALUOp     = ctrl.alu_op;
  assign PCSrc     = ctrl.pc_src;
  assign IllegalOp = ctrl.illegal_op;
  assign State     = state;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one parameter: ILLEGAL_HALT, default 0, meaning 1 = park in HALT on an undecodable opcode and 0 = return to FETCH.
REQ-002 CLK  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 Opcode  input  6  IR[31:26]; the external IR SHALL hold it stable from DECODE through end of instruction.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 PCEn  output  1  PC register write enable.
REQ-007 IorDSel  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 IRWE  output  1  IR write enable.
REQ-009 DMWE  output  1  data memory write enable.
REQ-010 RFWE  output  1  register file write enable.
REQ-011 RFDSel  output  1  RF destination select: 1 = rd, 0 = rt.
REQ-012 MtoRFSel  output  1  RF write-data select: 1 = memory data register, 0 = ALUOut.
REQ-013 ALUIn1Sel  output  1  ALU input 1 select: 0 = PC, 1 = register A.
REQ-014 ALUIn2Sel  output  2  ALU input 2 select: 00 = register B, 01 = constant 1, 10 = Simm.
REQ-015 ALUOp  output  2  ALU operation: 00 = add, 01 = subtract, 11 = decode funct.
REQ-016 PCSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = JTA.
REQ-017 IllegalOp  output  1  one-cycle flag for an undecodable opcode.
REQ-018 State  output  4  current state encoding, for debug.

Function
REQ-019 Outputs SHALL be Moore-decoded from the state, except PCEn in BRANCH; any output not named for a state SHALL be 0 (never X/Z).
REQ-020 FETCH SHALL assert IorDSel=0, IRWE=1, ALUIn1Sel=0, ALUIn2Sel=01, ALUOp=00, PCSrc=00, PCEn=1 (PC+1, word addressing), then go to DECODE.
REQ-021 DECODE SHALL assert ALUIn1Sel=0, ALUIn2Sel=10, ALUOp=00 (branch target into ALUOut), then go by Opcode:
- 100011 (lw) / 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC_R
- 001000 (addi) -> EXEC_I
- 000100 (beq) -> BRANCH
- 000010 (j) -> JUMP
- any other -> IllegalOp=1 this cycle, then HALT if ILLEGAL_HALT=1, else FETCH.
REQ-022 MEMADR SHALL assert ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00; lw -> MEMRD, sw -> MEMWR.
REQ-023 MEMRD SHALL assert IorDSel=1 -> MEMWB; MEMWB SHALL assert RFWE=1, RFDSel=0, MtoRFSel=1 -> FETCH.
REQ-024 MEMWR SHALL assert IorDSel=1, DMWE=1 -> FETCH.
REQ-025 EXEC_R SHALL assert ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=11 -> WB_R; WB_R SHALL assert RFWE=1, RFDSel=1, MtoRFSel=0 -> FETCH.
REQ-026 EXEC_I SHALL assert ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00 -> WB_I; WB_I SHALL assert RFWE=1, RFDSel=0, MtoRFSel=0 -> FETCH.
REQ-027 BRANCH SHALL assert ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=01, PCSrc=01, PCEn=Zero (combinational) -> FETCH.
REQ-028 JUMP SHALL assert PCSrc=10, PCEn=1 -> FETCH.
REQ-029 HALT SHALL drive all enables 0 and remain until RST.
REQ-030 Latency in cycles SHALL be lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
REQ-031 Opcode changes outside DECODE and MEMADR SHALL not affect state transitions.

Reset
REQ-032 RST high at a rising edge SHALL load FETCH regardless of current state, including mid-instruction and HALT.
REQ-033 While RST is high, PCEn, IRWE, DMWE, RFWE and IllegalOp SHALL be forced 0.

Structure
REQ-034 Opcode constants, state encodings and ALUOp/ALUIn2Sel/PCSrc codes SHALL live in a shared package (mips_pkg) with the datapath.
REQ-035 The block SHALL be a single module with no sub-modules; next-state and output logic SHALL be separate processes.

Verification
REQ-036 Cover lw, opcode 100011, after reset -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RFWE=1 only in cycle 5 with MtoRFSel=1, RFDSel=0.
REQ-037 Cover sw, opcode 101011 -> DMWE=1 only in cycle 4 with IorDSel=1; RFWE stays 0 throughout.
REQ-038 Cover beq, opcode 000100, Zero=1 -> PCEn=1, PCSrc=01 in cycle 3; with Zero=0 -> PCEn=0 in cycle 3.
REQ-039 Cover j, opcode 000010 -> PCSrc=10, PCEn=1 in cycle 3; next cycle is FETCH.
REQ-040 Cover illegal opcode 111111 -> IllegalOp=1 in DECODE; ILLEGAL_HALT=0 gives FETCH next, ILLEGAL_HALT=1 gives HALT until RST.
REQ-041 Cover RST asserted in EXEC_R -> WB_R skipped, RFWE=0, state is FETCH on the following cycle.
